counter_step_ctrl: RTL and testbench

Push-button front end sitting directly upstream of the 8-bit up/down counter. Synchronises and debounces two raw buttons and converts presses into the counter's `enable` and `direction` controls. One clean press gives one single-cycle count step. Holding a button auto-repeats after a delay.

---
 rtl/counter_step_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_counter_step_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : counter_step_ctrl
// Description : Push-button front end for an 8-bit up/down counter.
//               Synchronises and debounces two raw buttons and turns presses
//               into a single-cycle step strobe plus a direction bit. A held
//               button auto-repeats after REPEAT_DELAY cycles, then every
//               REPEAT_RATE cycles. Pressing both buttons locks stepping out
//               until both are released.
// Ports       : clk           - sole clock, rising edge
//               rst           - asynchronous, active-low reset
//               btn_up        - raw up button (async, active-high)
//               btn_down      - raw down button (async, active-high)
//               enable        - single-cycle step strobe to the counter
//               direction     - step direction, 1 = up, 0 = down
//               repeat_active - high while auto-repeating
// Revision    : 1.0 - initial release
// ============================================================================
module counter_step_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 16,
    parameter int REPEAT_RATE     = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_up,
    input  logic btn_down,
    output logic enable,
    output logic direction,
    output logic repeat_active
);

    // A debounce count only ever reaches DEBOUNCE_CYCLES-1 before the level
    // flips, so $clog2(DEBOUNCE_CYCLES) bits suffice (min 1 bit).
    localparam int c_DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int c_TMR_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int c_TMR_W   = $clog2(c_TMR_MAX);

    localparam logic [c_DB_W-1:0]  c_DB_LAST    = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_TMR_W-1:0] c_DELAY_LAST = c_TMR_W'(REPEAT_DELAY - 1);
    localparam logic [c_TMR_W-1:0] c_RATE_LAST  = c_TMR_W'(REPEAT_RATE - 1);

    // Bit 1 = up button, bit 0 = down button.
    logic [1:0] btn_raw;
    logic [1:0] db_level;

    assign btn_raw = {btn_up, btn_down};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            logic              sync1_q;
            logic              sync2_q;
            logic              level_q;
            logic              level_d;
            logic [c_DB_W-1:0] cnt_q;
            logic [c_DB_W-1:0] cnt_d;

            // Count consecutive samples disagreeing with the accepted level;
            // any agreeing sample restarts the run.
            always_comb begin
                cnt_d   = '0;
                level_d = level_q;
                if (sync2_q != level_q) begin
                    if (cnt_q == c_DB_LAST) begin
                        level_d = ~level_q;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    sync1_q <= 1'b0;
                    sync2_q <= 1'b0;
                    level_q <= 1'b0;
                    cnt_q   <= '0;
                end else begin
                    sync1_q <= btn_raw[gi];
                    sync2_q <= sync1_q;
                    level_q <= level_d;
                    cnt_q   <= cnt_d;
                end
            end

            assign db_level[gi] = level_q;
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FIRST   = 3'd1,
        S_DELAY   = 3'd2,
        S_REPEAT  = 3'd3,
        S_LOCKOUT = 3'd4
    } state_t;

    state_t               state_q;
    logic [c_TMR_W-1:0]   timer_q;
    logic                 enable_q;
    logic                 direction_q;
    logic                 repeat_q;

    logic up_lvl;
    logic dn_lvl;
    logic act_lvl;
    logic oth_lvl;

    assign up_lvl  = db_level[1];
    assign dn_lvl  = db_level[0];
    // direction_q remembers which button started the current run.
    assign act_lvl = direction_q ? up_lvl : dn_lvl;
    assign oth_lvl = direction_q ? dn_lvl : up_lvl;

    // The timer is cleared on every issued step and compared against the
    // last count, so steps land exactly REPEAT_DELAY / REPEAT_RATE edges apart.
    // Release takes priority over the other button in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            enable_q    <= 1'b0;
            direction_q <= 1'b1;
            repeat_q    <= 1'b0;
        end else begin
            enable_q <= 1'b0;
            repeat_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (up_lvl ^ dn_lvl) begin
                        enable_q    <= 1'b1;
                        direction_q <= up_lvl;
                        timer_q     <= '0;
                        state_q     <= S_FIRST;
                    end else if (up_lvl & dn_lvl) begin
                        state_q <= S_LOCKOUT;
                    end
                end
                S_FIRST, S_DELAY: begin
                    if (!act_lvl) begin
                        state_q <= S_IDLE;
                    end else if (oth_lvl) begin
                        state_q <= S_LOCKOUT;
                    end else if (timer_q == c_DELAY_LAST) begin
                        enable_q <= 1'b1;
                        repeat_q <= 1'b1;
                        timer_q  <= '0;
                        state_q  <= S_REPEAT;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                        state_q <= S_DELAY;
                    end
                end
                S_REPEAT: begin
                    if (!act_lvl) begin
                        state_q <= S_IDLE;
                    end else if (oth_lvl) begin
                        state_q <= S_LOCKOUT;
                    end else begin
                        repeat_q <= 1'b1;
                        if (timer_q == c_RATE_LAST) begin
                            enable_q <= 1'b1;
                            timer_q  <= '0;
                        end else begin
                            timer_q <= timer_q + 1'b1;
                        end
                    end
                end
                S_LOCKOUT: begin
                    if (!up_lvl && !dn_lvl) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign enable        = enable_q;
    assign direction     = direction_q;
    assign repeat_active = repeat_q;

endmodule
`default_nettype wire

// File: tb/tb_counter_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_counter_step_ctrl
// Description : Self-checking bench for counter_step_ctrl. A behavioural
//               model (sample history, run-length debounce, step-time
//               arithmetic) is compared with the DUT on every cycle; directed
//               scenarios pin the model with hand-derived step offsets.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_step_ctrl;

    localparam int DEB    = 4;
    localparam int RDELAY = 16;
    localparam int RRATE  = 4;

    logic clk      = 1'b0;
    logic rst      = 1'b0;
    logic btn_up   = 1'b0;
    logic btn_down = 1'b0;
    logic enable;
    logic direction;
    logic repeat_active;

    counter_step_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY   (RDELAY),
        .REPEAT_RATE    (RRATE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_up       (btn_up),
        .btn_down     (btn_down),
        .enable       (enable),
        .direction    (direction),
        .repeat_active(repeat_active)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 = idle, 1 = stepping a held button, 2 = locked out.
    // m_k = edges since the first step of the current run; steps fall at
    // k = 0, RDELAY, RDELAY + n*RRATE.
    logic [1:0] m_s1  = 2'b00;
    logic [1:0] m_s2  = 2'b00;
    logic [1:0] m_lvl = 2'b00;
    int         m_cnt [2];
    int         m_mode = 0;
    int         m_k    = 0;
    logic       m_en   = 1'b0;
    logic       m_dir  = 1'b1;
    logic       m_rep  = 1'b0;
    logic       m_up, m_dn, m_act, m_oth;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_s1 = 2'b00; m_s2 = 2'b00; m_lvl = 2'b00;
            m_cnt[0] = 0; m_cnt[1] = 0;
            m_mode = 0; m_k = 0;
            m_en = 1'b0; m_dir = 1'b1; m_rep = 1'b0;
        end else begin
            m_up = m_lvl[1];
            m_dn = m_lvl[0];
            m_en = 1'b0;
            if (m_mode == 0) begin
                if (m_up ^ m_dn) begin
                    m_en = 1'b1; m_dir = m_up; m_mode = 1; m_k = 0;
                end else if (m_up & m_dn) begin
                    m_mode = 2;
                end
            end else if (m_mode == 1) begin
                m_act = m_dir ? m_up : m_dn;
                m_oth = m_dir ? m_dn : m_up;
                if (!m_act) begin
                    m_mode = 0;
                end else if (m_oth) begin
                    m_mode = 2;
                end else begin
                    m_k = m_k + 1;
                    if (m_k == RDELAY || (m_k > RDELAY && (m_k - RDELAY) % RRATE == 0))
                        m_en = 1'b1;
                end
            end else begin
                if (!m_up && !m_dn) m_mode = 0;
            end
            m_rep = (m_mode == 1) && (m_k >= RDELAY);
            for (int b = 0; b < 2; b++) begin
                if (m_s2[b] != m_lvl[b]) begin
                    m_cnt[b] = m_cnt[b] + 1;
                    if (m_cnt[b] >= DEB) begin
                        m_lvl[b] = ~m_lvl[b];
                        m_cnt[b] = 0;
                    end
                end else begin
                    m_cnt[b] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = {btn_up, btn_down};
        end
    end

    // ---------------- per-cycle compare ----------------
    logic prev_en = 1'b0;

    always @(negedge clk) begin
        chk("enable", enable, m_en);
        chk("direction", direction, m_dir);
        chk("repeat_active", repeat_active, m_rep);
        chk("enable_single_cycle", enable & prev_en, 1'b0);
        prev_en <= enable;
    end

    // ---------------- step log and downstream counter ----------------
    int   base = 0;
    int   log_q [$];
    logic dir_q [$];
    int   exp_q [$];
    int   rep_first = -1;
    int   rep_last  = -1;
    logic [7:0] cnt8;

    always @(negedge clk) begin
        if (enable === 1'b1) begin
            log_q.push_back(cyc - base - 1);
            dir_q.push_back(direction);
        end
        if (repeat_active === 1'b1) begin
            if (rep_first < 0) rep_first = cyc - base - 1;
            rep_last = cyc - base - 1;
        end
    end

    always @(negedge clk or negedge rst) begin
        if (!rst)                cnt8 <= 8'd0;
        else if (enable === 1'b1) cnt8 <= direction ? cnt8 + 8'd1 : cnt8 - 8'd1;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge together with a button change: offsets are then
    // counted in edges from the first edge that sees the new level.
    task automatic start_rec();
        base = cyc;
        log_q.delete();
        dir_q.delete();
        rep_first = -1;
        rep_last  = -1;
    endtask

    task automatic check_log(input string name, input logic exp_dir);
        chk_int({name, "_count"}, log_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            chk_int($sformatf("%s_offset%0d", name, i), log_q[i], exp_q[i]);
            chk($sformatf("%s_dir%0d", name, i), dir_q[i], exp_dir);
        end
    endtask

    initial begin
        int r, pat, dur;
        m_cnt[0] = 0;
        m_cnt[1] = 0;

        cycles(3);
        chk("reset_enable", enable, 1'b0);
        chk("reset_direction", direction, 1'b1);
        chk("reset_repeat", repeat_active, 1'b0);
        rst = 1'b1;
        cycles(3);

        // Single up press: one step at edge 6.
        btn_up = 1'b1; start_rec(); cycles(10); btn_up = 1'b0; cycles(20);
        exp_q = '{6};
        check_log("single_up", 1'b1);
        chk_int("single_up_counter", int'(cnt8), 1);

        // Down glitch of 3 cycles: nothing.
        btn_down = 1'b1; start_rec(); cycles(3); btn_down = 1'b0; cycles(15);
        exp_q.delete();
        check_log("glitch", 1'b0);
        chk("glitch_direction", direction, 1'b1);

        // Down held 40 cycles: auto-repeat.
        btn_down = 1'b1; start_rec(); cycles(40); btn_down = 1'b0; cycles(20);
        exp_q = '{6, 22, 26, 30, 34, 38, 42};
        check_log("repeat_down", 1'b0);
        chk_int("repeat_first", rep_first, 22);
        chk_int("repeat_last", rep_last, 45);
        chk_int("repeat_counter", int'(cnt8), 250);

        // Both buttons: lockout, one-sided release, then a fresh down press.
        btn_up = 1'b1; start_rec(); cycles(12); btn_down = 1'b1; cycles(20);
        exp_q = '{6};
        check_log("both_lock", 1'b1);
        btn_up = 1'b0; cycles(25);
        check_log("both_up_released", 1'b1);
        btn_down = 1'b0; cycles(15);
        btn_down = 1'b1; start_rec(); cycles(10); btn_down = 1'b0; cycles(20);
        check_log("both_then_down", 1'b0);

        // Reset mid-run, in the cycle of the second step, with btn_up held.
        btn_up = 1'b1; start_rec();
        repeat (23) @(posedge clk);
        #2;
        chk("pre_reset_enable", enable, 1'b1);
        chk("pre_reset_repeat", repeat_active, 1'b1);
        rst = 1'b0;
        #1;
        chk("midrun_reset_enable", enable, 1'b0);
        chk("midrun_reset_direction", direction, 1'b1);
        chk("midrun_reset_repeat", repeat_active, 1'b0);
        @(negedge clk); @(negedge clk);
        rst = 1'b1; start_rec(); cycles(10); btn_up = 1'b0; cycles(20);
        exp_q = '{6};
        check_log("after_reset", 1'b1);
        chk_int("after_reset_counter", int'(cnt8), 1);

        // Counter wrap: from 0, one down step.
        #2; rst = 1'b0; @(negedge clk); rst = 1'b1; cycles(2);
        btn_down = 1'b1; start_rec(); cycles(10); btn_down = 1'b0; cycles(20);
        check_log("wrap_down", 1'b0);
        chk_int("wrap_counter", int'(cnt8), 255);

        // Randomised button activity against the model.
        for (int seg = 0; seg < 150; seg++) begin
            r = $urandom_range(0, 99);
            if (r < 4) begin
                #2; rst = 1'b0;
                @(negedge clk);
                rst = 1'b1;
            end else begin
                pat = $urandom_range(0, 9);
                btn_up   = (pat >= 2 && pat <= 4) || pat >= 8;
                btn_down = (pat >= 5);
                dur = (r < 20) ? $urandom_range(1, 3) : $urandom_range(4, 40);
                cycles(dur);
            end
        end
        btn_up = 1'b0; btn_down = 1'b0;
        cycles(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
